// File: rtl/mult8_seq_pkg.sv
// Shared types and derived sizes for the sequential 8x8 multiplier.
package mult8_seq_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SLICE = 2;
  localparam int unsigned STEPS = WIDTH / SLICE;
  localparam int unsigned SKW   = $clog2(STEPS);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned PPW   = WIDTH + SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The first slice processed can be at most the last one, so at least one RUN edge occurs.
  function automatic logic [SKW-1:0] clamp_skip(input logic [SKW-1:0] s);
    if (32'(s) > STEPS - 1) begin
      return SKW'(STEPS - 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// Request/response handshake bundle between requester, sequencer and consumer.
import mult8_seq_pkg::*;

interface mult8_seq_ctrl_if;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [SKW-1:0]   in_skip;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_p;

  modport slave (
    input  in_valid, in_a, in_b, in_skip, out_ready,
    output in_ready, out_valid, out_p
  );

  modport master (
    output in_valid, in_a, in_b, in_skip, out_ready,
    input  in_ready, out_valid, out_p
  );
endinterface

// File: rtl/mult8_pp_slice.sv
// Combinational partial product of the full multiplicand and one multiplier slice.
import mult8_seq_pkg::*;

module mult8_pp_slice (
  input  logic [WIDTH-1:0] a_i,
  input  logic [SLICE-1:0] bs_i,
  output logic [PPW-1:0]   pp_o
);

  assign pp_o = PPW'(a_i) * PPW'(bs_i);

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Multi-cycle unsigned multiplier: one B slice per cycle through a shared slice,
// with an optional count of low slices skipped for approximate results.
import mult8_seq_pkg::*;

module mult8_seq_ctrl (
  input  logic             clk,
  input  logic             rst,
  mult8_seq_ctrl_if.slave  bus,
  output logic             busy
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SKW-1:0]   idx_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    out_p_q;
  logic             out_valid_q;
  logic [SLICE-1:0] bs;
  logic [PPW-1:0]   pp;

  assign bs = b_q[SLICE*idx_q +: SLICE];

  mult8_pp_slice u_pp (
    .a_i  (a_q),
    .bs_i (bs),
    .pp_o (pp)
  );

  // Shifted partial product for the current slice added into the running sum.
  assign acc_d = acc_q + (PW'(pp) << (SLICE * idx_q));

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
  assign busy          = (state_q != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            idx_q   <= clamp_skip(bus.in_skip);
            acc_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (idx_q == SKW'(STEPS - 1)) begin
            out_p_q     <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q <= acc_d;
            idx_q <= idx_q + SKW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl: directed vectors, corner sequences, random back-to-back.
module tb_mult8_seq_ctrl;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   failures;
  int   cyc;

  mult8_seq_ctrl_if bus();

  mult8_seq_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  skip;
    logic [15:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: skipped low slices are treated as zero bits of B.
  function automatic int ref_k(input logic [1:0] s);
    return (int'(s) > 3) ? 3 : int'(s);
  endfunction

  function automatic logic [15:0] ref_p(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    logic [7:0] mask;
    mask = 8'hFF;
    mask = mask << (2 * ref_k(s));
    return 16'(a) * 16'(b & mask);
  endfunction

  task automatic do_req(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                        output logic [15:0] p, output int lat);
    @(negedge clk);
    chk("req_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_a = a; bus.in_b = b; bus.in_skip = s;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus.out_p;
    @(posedge clk); #1;
    chk("valid_one_cycle", 32'(bus.out_valid), 32'd0);
    chk("ready_after_take", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] held;
    int lat;
    int w;
    int prev_acc;
    int prev_n;
    logic [7:0] ra, rb;
    logic [1:0] rs;

    checks = 0; failures = 0; cyc = 0;
    vecs[0] = '{8'd255, 8'd255, 2'd0, 16'd65025, 4};
    vecs[1] = '{8'd200, 8'h0F,  2'd1, 16'd2400,  3};
    vecs[2] = '{8'd1,   8'hFF,  2'd3, 16'h00C0,  1};
    vecs[3] = '{8'd0,   8'd0,   2'd0, 16'd0,     4};
    vecs[4] = '{8'd3,   8'd5,   2'd0, 16'd15,    4};
    vecs[5] = '{8'd255, 8'hFF,  2'd3, 16'd48960, 1};
    vecs[6] = '{8'd128, 8'hAA,  2'd2, 16'd20480, 2};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_skip = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_p", 32'(bus.out_p), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) begin
      do_req(vecs[i].a, vecs[i].b, vecs[i].skip, p, lat);
      chk($sformatf("vec%0d_p", i), 32'(p), 32'(vecs[i].exp_p));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure: product held, new requests refused while DONE.
    @(negedge clk);
    bus.in_a = 8'd77; bus.in_b = 8'd9; bus.in_skip = 2'd0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 12) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_lat", 32'(w), 32'd4);
    held = bus.out_p;
    chk("bp_p", 32'(held), 32'd693);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_a = 8'(c + 1); bus.in_b = 8'hFF;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp_p_stable", 32'(bus.out_p), 32'(held));
      chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);

    // Reset landing on the second RUN edge abandons the operation.
    @(negedge clk);
    bus.in_a = 8'd99; bus.in_b = 8'd99; bus.in_skip = 2'd0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_p", 32'(bus.out_p), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", 32'(bus.in_ready), 32'd1);
    do_req(8'd3, 8'd5, 2'd0, p, lat);
    chk("after_rst_p", 32'(p), 32'd15);
    chk("after_rst_lat", 32'(lat), 32'd4);

    // Back-to-back random requests with in_valid held and out_ready high.
    bus.out_ready = 1'b1;
    prev_acc = 0; prev_n = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 2'($urandom);
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w >= 20) chk("rnd_accept_timeout", 32'(w), 32'd0);
      bus.in_a = ra; bus.in_b = rb; bus.in_skip = rs; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      if (i > 0) chk("rnd_period", 32'(cyc - prev_acc), 32'(prev_n + 2));
      prev_acc = cyc;
      prev_n = 4 - ref_k(rs);
      bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_skip = 2'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 12) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("rnd_lat", 32'(lat), 32'(prev_n));
      chk("rnd_p", 32'(bus.out_p), 32'(ref_p(ra, rb, rs)));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
